arc4_ctrl: RTL and testbench
============================

ARC4_CTRL -- requirements
Module: arc4_ctrl

Interface
REQ-001 Parameter: KEY_W, 24, width of the latched key.
REQ-002 Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  start request from top level.
- rdy  out  1  controller idle and able to accept en.
- key  in  KEY_W  decryption key, sampled on accepted en.
- key_q  out  KEY_W  latched key, driven to KSA.
- init_en / ksa_en / prga_en  out  1 each  one-cycle start pulse to the sub-block.
- init_rdy / ksa_rdy / prga_rdy  in  1 each  sub-block idle.
- init_addr, ksa_addr, prga_addr  in  8 each  S-memory address from each requester.
- init_wrdata, ksa_wrdata, prga_wrdata  in  8 each  S-memory write data.
- init_wren, ksa_wren, prga_wren  in  1 each  S-memory write enable.
- s_addr  out  8  shared S-memory address.
- s_wrdata  out  8  shared S-memory write data.
- s_wren  out  1  shared S-memory write enable.
- phase  out  2  owner: 0 none, 1 init, 2 ksa, 3 prga.
- err  out  1  sticky: a non-owner asserted wren.

Function
REQ-003 The FSM SHALL have states IDLE, INIT_GO, INIT_BUSY, KSA_GO, KSA_BUSY, PRGA_GO, PRGA_BUSY.
REQ-004 rdy SHALL be 1 only in IDLE; the value is decoded from the state register.
REQ-005 In IDLE, en=1 SHALL latch key into key_q, clear err, and move to INIT_GO at the same edge; en while rdy=0 SHALL be ignored.
REQ-006 In X_GO, X_en SHALL be 1 combinationally iff X_rdy=1; on an edge with X_rdy=1 the FSM SHALL move to X_BUSY; with X_rdy=0 it SHALL hold in X_GO.
REQ-007 X_en SHALL never be asserted for more than one cycle per phase, and never outside X_GO.
REQ-008 In X_BUSY, X_rdy=1 SHALL advance the FSM: INIT_BUSY->KSA_GO, KSA_BUSY->PRGA_GO, PRGA_BUSY->IDLE; X_rdy=0 holds.
REQ-009 A sub-block SHALL drop rdy in the cycle after its en; the controller SHALL NOT detect completion in the first BUSY cycle unless X_rdy=1 is sampled there.
REQ-010 S-memory mux SHALL be combinational on state: INIT_* selects init_*, KSA_* selects ksa_*, PRGA_* selects prga_*; IDLE drives s_addr=0, s_wrdata=0, s_wren=0.
REQ-011 phase SHALL equal 1/2/3 in INIT_*/KSA_*/PRGA_* and 0 in IDLE.
REQ-012 Any cycle in which a non-selected requester has wren=1 SHALL set err at the next edge; that write SHALL NOT reach s_wren; err holds until the next accepted en or reset.
REQ-013 In IDLE, any requester wren=1 SHALL set err.
REQ-014 Minimum latency from accepted en to rdy=1 SHALL be 6 cycles plus the sub-block busy durations (each GO and BUSY state occupies at least one cycle).
REQ-015 key_q SHALL remain stable from acceptance until the next accepted en.

Reset
REQ-016 rst_n=0 SHALL immediately force: state IDLE, rdy=1, all X_en=0, s_wren=0, s_addr=0, s_wrdata=0, phase=0, err=0, key_q=0.
REQ-017 Reset asserted mid-phase SHALL abort the sequence with no further X_en pulses; after release, the controller SHALL wait for a fresh en.

Verification
REQ-018 Behavioural sub-block models have busy times of 256 (init), 768 (ksa) and 20 (prga) cycles. Required scenarios:
- Nominal run: en=1 with key=24'h00033C -> exactly one init_en, ksa_en and prga_en pulse in that order; key_q=24'h00033C; rdy returns 1050 cycles after acceptance (6 controller cycles plus 1044 busy).
- Stalled start: ksa_rdy is held 0 for 5 cycles on entry to KSA_GO -> FSM holds in KSA_GO; ksa_en stays 0 until ksa_rdy=1, then is a single one-cycle pulse.
- Mux ownership: during KSA_BUSY, ksa drives addr=8'h7F, wrdata=8'hA5, wren=1 -> s_addr=8'h7F, s_wrdata=8'hA5, s_wren=1, phase=2.
- Intruder write: during KSA_BUSY, init_wren=1 for one cycle -> s_wren follows ksa_wren only, and err=1 from the next edge until the next accepted en.
- Ignored en: en is pulsed during PRGA_BUSY -> no restart; key_q is unchanged.
- Mid-run reset: rst_n=0 is asserted during KSA_BUSY -> rdy=1, phase=0, s_wren=0 immediately; no prga_en pulse ever follows.

Source files
------------

// File: rtl/arc4_ctrl_if.sv
// Bundle of the start/ready handshake, key path and shared S-memory request
// lines around the ARC4 sequencing controller. The controller connects through
// the master view; the surrounding top level and sub-blocks use the slave view.
interface arc4_ctrl_if #(
  parameter int KEY_W = 24
);

  // Top-level handshake and key
  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] key_q;

  // Start pulses and idle flags of the three sub-blocks
  logic init_en;
  logic ksa_en;
  logic prga_en;
  logic init_rdy;
  logic ksa_rdy;
  logic prga_rdy;

  // S-memory requests from each sub-block
  logic [7:0] init_addr;
  logic [7:0] ksa_addr;
  logic [7:0] prga_addr;
  logic [7:0] init_wrdata;
  logic [7:0] ksa_wrdata;
  logic [7:0] prga_wrdata;
  logic       init_wren;
  logic       ksa_wren;
  logic       prga_wren;

  // Shared S-memory port and status
  logic [7:0] s_addr;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [1:0] phase;
  logic       err;

  modport master (
    input  en, key,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output rdy, key_q,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren,
    output phase, err
  );

  modport slave (
    output en, key,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  rdy, key_q,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren,
    input  phase, err
  );

endinterface

// File: rtl/arc4_ctrl.sv
// ARC4 sequencing controller. On an accepted start it latches the key and walks
// the init, KSA and PRGA sub-blocks in order, giving each a single start pulse
// once it reports idle, then waiting for it to report idle again. While a
// sub-block owns the sequence, its S-memory requests are routed to the shared
// port; a write attempt from any other requester is dropped and flagged in a
// sticky error bit that is cleared only by the next accepted start or reset.
module arc4_ctrl #(
  parameter int KEY_W = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  arc4_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_GO   = 3'd1,
    INIT_BUSY = 3'd2,
    KSA_GO    = 3'd3,
    KSA_BUSY  = 3'd4,
    PRGA_GO   = 3'd5,
    PRGA_BUSY = 3'd6
  } stateT;

  stateT            state_q;
  stateT            state_d;
  logic [KEY_W-1:0] keyReg_q;
  logic [KEY_W-1:0] keyReg_d;
  logic             err_q;
  logic             err_d;

  logic             accept;
  logic             intrude;
  logic             rdyOut;
  logic [1:0]       phaseOut;
  logic             initEn;
  logic             ksaEn;
  logic             prgaEn;
  logic [7:0]       sAddr;
  logic [7:0]       sWrdata;
  logic             sWren;

  // A start request is only honoured while the controller sits in IDLE.
  assign accept = (state_q == IDLE) && bus.en;

  // State register; reset abandons any sequence in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: each GO state waits for its sub-block to be idle (the same edge
  // that carries the start pulse), each BUSY state waits for it to be idle again.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.en)       state_d = INIT_GO;
      INIT_GO:   if (bus.init_rdy) state_d = INIT_BUSY;
      INIT_BUSY: if (bus.init_rdy) state_d = KSA_GO;
      KSA_GO:    if (bus.ksa_rdy)  state_d = KSA_BUSY;
      KSA_BUSY:  if (bus.ksa_rdy)  state_d = PRGA_GO;
      PRGA_GO:   if (bus.prga_rdy) state_d = PRGA_BUSY;
      PRGA_BUSY: if (bus.prga_rdy) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state: ready flag, owner code, start pulses,
  // S-memory routing and detection of writes from requesters that do not own
  // the memory (every requester is an intruder while idle).
  always_comb begin
    rdyOut   = 1'b0;
    phaseOut = 2'd0;
    initEn   = 1'b0;
    ksaEn    = 1'b0;
    prgaEn   = 1'b0;
    sAddr    = 8'd0;
    sWrdata  = 8'd0;
    sWren    = 1'b0;
    intrude  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdyOut  = 1'b1;
        intrude = bus.init_wren | bus.ksa_wren | bus.prga_wren;
      end
      INIT_GO, INIT_BUSY: begin
        phaseOut = 2'd1;
        initEn   = (state_q == INIT_GO) && bus.init_rdy;
        sAddr    = bus.init_addr;
        sWrdata  = bus.init_wrdata;
        sWren    = bus.init_wren;
        intrude  = bus.ksa_wren | bus.prga_wren;
      end
      KSA_GO, KSA_BUSY: begin
        phaseOut = 2'd2;
        ksaEn    = (state_q == KSA_GO) && bus.ksa_rdy;
        sAddr    = bus.ksa_addr;
        sWrdata  = bus.ksa_wrdata;
        sWren    = bus.ksa_wren;
        intrude  = bus.init_wren | bus.prga_wren;
      end
      PRGA_GO, PRGA_BUSY: begin
        phaseOut = 2'd3;
        prgaEn   = (state_q == PRGA_GO) && bus.prga_rdy;
        sAddr    = bus.prga_addr;
        sWrdata  = bus.prga_wrdata;
        sWren    = bus.prga_wren;
        intrude  = bus.init_wren | bus.ksa_wren;
      end
      default: begin
        rdyOut = 1'b0;
      end
    endcase
  end

  // Key and error next values: a new start reloads the key and restarts error
  // tracking, but an intrusion seen in that same cycle still sets the flag.
  always_comb begin
    keyReg_d = keyReg_q;
    err_d    = err_q | intrude;
    if (accept) begin
      keyReg_d = bus.key;
      err_d    = intrude;
    end
  end

  // Key and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keyReg_q <= '0;
      err_q    <= 1'b0;
    end else begin
      keyReg_q <= keyReg_d;
      err_q    <= err_d;
    end
  end

  assign bus.rdy      = rdyOut;
  assign bus.phase    = phaseOut;
  assign bus.init_en  = initEn;
  assign bus.ksa_en   = ksaEn;
  assign bus.prga_en  = prgaEn;
  assign bus.s_addr   = sAddr;
  assign bus.s_wrdata = sWrdata;
  assign bus.s_wren   = sWren;
  assign bus.key_q    = keyReg_q;
  assign bus.err      = err_q;

  // Start pulses never overlap, never last beyond one cycle, and the shared
  // port is never written without an owner.
  assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({initEn, ksaEn, prgaEn}));
  assert property (@(posedge clk) disable iff (!rst_n) initEn |=> !initEn);
  assert property (@(posedge clk) disable iff (!rst_n) ksaEn  |=> !ksaEn);
  assert property (@(posedge clk) disable iff (!rst_n) prgaEn |=> !prgaEn);
  assert property (@(posedge clk) disable iff (!rst_n) sWren |-> (phaseOut != 2'd0));

endmodule

// File: tb/tb_arc4_ctrl.sv
// Bench for the ARC4 sequencing controller. Behavioural sub-blocks answer the
// start pulses with fixed busy times; a phase/owner reference model predicts
// every controller output each cycle from randomized requester traffic.
`timescale 1ns/1ps
module tb_arc4_ctrl;

  localparam int KEY_W        = 24;
  localparam int INIT_CYC     = 256;
  localparam int KSA_CYC      = 768;
  localparam int PRGA_CYC     = 20;
  localparam int NOMINAL_LAT  = 6 + INIT_CYC + KSA_CYC + PRGA_CYC;
  localparam int WAIT_LIMIT   = 3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  arc4_ctrl_if #(.KEY_W(KEY_W)) bus ();

  arc4_ctrl #(.KEY_W(KEY_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: owning phase (0 none, 1..3) and whether its start is pending
  int               expPhase;
  bit               expGo;
  logic [KEY_W-1:0] expKey;
  bit               expErr;

  // Sub-block environment and requester traffic, indexed by phase number
  int         busyCnt  [1:3];
  int         stallCnt [1:3];
  int         busyLen  [1:3];
  logic [7:0] reqAddr  [1:3];
  logic [7:0] reqData  [1:3];
  bit         reqWren  [1:3];

  bit intrudeOn;
  bit randStall;
  bit stallKsaNext;
  int stallSum;
  int pulseLog [$];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic bit subRdy(input int i);
    return (busyCnt[i] == 0) && (stallCnt[i] == 0);
  endfunction

  function automatic int enterStall(input int p);
    int s;
    s = 0;
    if (p == 2 && stallKsaNext) begin
      s = 5;
      stallKsaNext = 1'b0;
    end else if (randStall) begin
      s = $urandom_range(0, 3);
    end
    stallSum += s;
    return s;
  endfunction

  task automatic resetModel();
    expPhase = 0;
    expGo    = 1'b0;
    expKey   = '0;
    expErr   = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      busyCnt[i]  = 0;
      stallCnt[i] = 0;
    end
  endtask

  task automatic driveBus();
    bus.init_rdy    = subRdy(1);
    bus.ksa_rdy     = subRdy(2);
    bus.prga_rdy    = subRdy(3);
    bus.init_addr   = reqAddr[1];
    bus.ksa_addr    = reqAddr[2];
    bus.prga_addr   = reqAddr[3];
    bus.init_wrdata = reqData[1];
    bus.ksa_wrdata  = reqData[2];
    bus.prga_wrdata = reqData[3];
    bus.init_wren   = reqWren[1];
    bus.ksa_wren    = reqWren[2];
    bus.prga_wren   = reqWren[3];
  endtask

  task automatic applyStimulus();
    for (int i = 1; i <= 3; i++) begin
      reqAddr[i] = 8'($urandom);
      reqData[i] = 8'($urandom);
      if (i == expPhase) reqWren[i] = ($urandom_range(0, 1) == 1);
      else               reqWren[i] = intrudeOn && ($urandom_range(0, 99) == 0);
    end
    driveBus();
  endtask

  // One clock: compare all outputs at the falling edge, advance the model and
  // the sub-blocks for the coming rising edge, then drive fresh inputs after it.
  task automatic stepCycle();
    bit         expEn [1:3];
    bit         dutEn [1:3];
    logic [7:0] eAddr;
    logic [7:0] eData;
    bit         eWren;
    bit         intr;
    bit         rCur;
    bit         accept;
    @(negedge clk);
    eAddr = 8'd0;
    eData = 8'd0;
    eWren = 1'b0;
    intr  = 1'b0;
    rCur  = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      expEn[i] = expGo && (expPhase == i) && subRdy(i);
      if (i == expPhase) begin
        eAddr = reqAddr[i];
        eData = reqData[i];
        eWren = reqWren[i];
        rCur  = subRdy(i);
      end else if (reqWren[i]) begin
        intr = 1'b1;
      end
    end
    dutEn[1] = bus.init_en;
    dutEn[2] = bus.ksa_en;
    dutEn[3] = bus.prga_en;

    checkOutput("rdy",      bus.rdy,      (expPhase == 0));
    checkOutput("phase",    bus.phase,    expPhase);
    checkOutput("init_en",  bus.init_en,  expEn[1]);
    checkOutput("ksa_en",   bus.ksa_en,   expEn[2]);
    checkOutput("prga_en",  bus.prga_en,  expEn[3]);
    checkOutput("s_addr",   bus.s_addr,   eAddr);
    checkOutput("s_wrdata", bus.s_wrdata, eData);
    checkOutput("s_wren",   bus.s_wren,   eWren);
    checkOutput("err",      bus.err,      expErr);
    checkOutput("key_q",    bus.key_q,    expKey);

    for (int i = 1; i <= 3; i++) if (dutEn[i]) pulseLog.push_back(i);

    if (!rst_n) begin
      resetModel();
    end else begin
      accept = (expPhase == 0) && bus.en;
      if (accept) begin
        expKey = bus.key;
        expErr = intr;
      end else if (intr) begin
        expErr = 1'b1;
      end
      for (int i = 1; i <= 3; i++) begin
        if (stallCnt[i] > 0) stallCnt[i]--;
        if (dutEn[i])            busyCnt[i] = busyLen[i];
        else if (busyCnt[i] > 0) busyCnt[i]--;
      end
      if (accept) begin
        expPhase    = 1;
        expGo       = 1'b1;
        stallCnt[1] = enterStall(1);
      end else if (expPhase != 0 && rCur) begin
        if (expGo) begin
          expGo = 1'b0;
        end else if (expPhase == 3) begin
          expPhase = 0;
        end else begin
          expPhase           = expPhase + 1;
          expGo              = 1'b1;
          stallCnt[expPhase] = enterStall(expPhase);
        end
      end
    end

    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  // Full start-to-idle sequence. scen 1: ownership and intruder writes during
  // KSA busy; scen 2: a start request while PRGA is busy.
  task automatic runSequence(input string name, input logic [KEY_W-1:0] seqKey,
                             input int scen, input bit ksaStall, input bit rndStall,
                             input bit intr);
    int n;
    int busyCycles;
    bit ignoreDone;
    bit enPulsed;
    int code;
    intrudeOn    = intr;
    randStall    = rndStall;
    stallKsaNext = ksaStall;
    stallSum     = 0;
    pulseLog.delete();
    busyCycles   = 0;
    ignoreDone   = 1'b0;
    enPulsed     = 1'b0;

    bus.key = seqKey;
    bus.en  = 1'b1;
    stepCycle();
    bus.en  = 1'b0;
    bus.key = KEY_W'($urandom);
    checkOutput({name, "_accepted"}, bus.rdy, 1'b0);
    if (!intr) checkOutput({name, "_err_cleared"}, bus.err, 1'b0);

    n = 0;
    while (!bus.rdy && n < WAIT_LIMIT) begin
      if (scen == 1 && expPhase == 2 && !expGo) begin
        busyCycles++;
        if (busyCycles == 10) begin
          reqAddr[2] = 8'h7F;
          reqData[2] = 8'hA5;
          reqWren    = '{1'b0, 1'b1, 1'b0};
          driveBus();
          #2;
          checkOutput("mux_s_addr",   bus.s_addr,   8'h7F);
          checkOutput("mux_s_wrdata", bus.s_wrdata, 8'hA5);
          checkOutput("mux_s_wren",   bus.s_wren,   1'b1);
          checkOutput("mux_phase",    bus.phase,    2'd2);
        end else if (busyCycles == 11) begin
          reqWren = '{1'b1, 1'b0, 1'b0};
          driveBus();
          #2;
          checkOutput("intruder_blocked", bus.s_wren, 1'b0);
          checkOutput("err_before_edge",  bus.err,    1'b0);
        end else if (busyCycles == 12) begin
          checkOutput("err_after_intruder", bus.err, 1'b1);
        end
      end
      if (scen == 2 && expPhase == 3 && !expGo && !ignoreDone) begin
        bus.en     = 1'b1;
        bus.key    = ~seqKey;
        ignoreDone = 1'b1;
        enPulsed   = 1'b1;
      end
      stepCycle();
      n++;
      if (enPulsed) begin
        bus.en   = 1'b0;
        enPulsed = 1'b0;
        checkOutput("ignored_en_key", bus.key_q, seqKey);
        checkOutput("ignored_en_phase", bus.phase, 2'd3);
      end
    end

    checkOutput({name, "_latency"}, n, NOMINAL_LAT + stallSum);
    checkOutput({name, "_pulse_count"}, pulseLog.size(), 3);
    code = 0;
    foreach (pulseLog[k]) code = code * 4 + pulseLog[k];
    checkOutput({name, "_pulse_order"}, code, 27);
    checkOutput({name, "_key_latched"}, bus.key_q, seqKey);
    if (scen == 1) checkOutput("err_sticky", bus.err, 1'b1);
  endtask

  // Abort during KSA busy and confirm the controller stays idle afterwards.
  task automatic midRunReset();
    int n;
    intrudeOn    = 1'b0;
    randStall    = 1'b0;
    stallKsaNext = 1'b0;
    pulseLog.delete();
    bus.key = 24'h5A5A5A;
    bus.en  = 1'b1;
    stepCycle();
    bus.en  = 1'b0;
    n = 0;
    while (!(expPhase == 2 && !expGo) && n < WAIT_LIMIT) begin
      stepCycle();
      n++;
    end
    checkOutput("reset_reached_ksa", bus.phase, 2'd2);
    repeat (7) stepCycle();
    reqWren[2] = 1'b1;
    driveBus();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_rdy",      bus.rdy,      1'b1);
    checkOutput("midreset_phase",    bus.phase,    2'd0);
    checkOutput("midreset_s_wren",   bus.s_wren,   1'b0);
    checkOutput("midreset_s_addr",   bus.s_addr,   8'd0);
    checkOutput("midreset_s_wrdata", bus.s_wrdata, 8'd0);
    checkOutput("midreset_err",      bus.err,      1'b0);
    checkOutput("midreset_key_q",    bus.key_q,    '0);
    checkOutput("midreset_ksa_en",   bus.ksa_en,   1'b0);
    resetModel();
    pulseLog.delete();
    driveBus();
    repeat (2) stepCycle();
    rst_n = 1'b1;
    repeat (1200) stepCycle();
    checkOutput("after_reset_no_pulses", pulseLog.size(), 0);
    checkOutput("after_reset_idle", bus.rdy, 1'b1);
  endtask

  initial begin
    busyLen[1]   = INIT_CYC;
    busyLen[2]   = KSA_CYC;
    busyLen[3]   = PRGA_CYC;
    intrudeOn    = 1'b0;
    randStall    = 1'b0;
    stallKsaNext = 1'b0;
    stallSum     = 0;
    for (int i = 1; i <= 3; i++) begin
      reqAddr[i] = 8'd0;
      reqData[i] = 8'd0;
      reqWren[i] = 1'b0;
    end
    resetModel();
    bus.en  = 1'b0;
    bus.key = '0;
    driveBus();

    #12;
    checkOutput("reset_rdy",    bus.rdy,    1'b1);
    checkOutput("reset_phase",  bus.phase,  2'd0);
    checkOutput("reset_err",    bus.err,    1'b0);
    checkOutput("reset_key_q",  bus.key_q,  '0);
    checkOutput("reset_s_wren", bus.s_wren, 1'b0);
    checkOutput("reset_en",     {bus.init_en, bus.ksa_en, bus.prga_en}, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus();
    repeat (3) stepCycle();

    $display("[TB] nominal run");
    runSequence("nominal", 24'h00033C, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) stepCycle();
    $display("[TB] stalled KSA start");
    runSequence("stall", 24'h123456, 0, 1'b1, 1'b0, 1'b0);
    repeat (2) stepCycle();
    $display("[TB] mux ownership and intruder write");
    runSequence("mux", 24'hC0FFEE, 1, 1'b0, 1'b0, 1'b0);
    repeat (2) stepCycle();
    $display("[TB] start ignored while busy");
    runSequence("ignore", 24'h0BEEF0, 2, 1'b0, 1'b0, 1'b0);
    repeat (2) stepCycle();
    $display("[TB] reset during KSA");
    midRunReset();
    for (int r = 0; r < 2; r++) begin
      $display("[TB] random run %0d", r);
      runSequence("random", KEY_W'($urandom), 0, 1'b0, 1'b1, 1'b1);
      repeat ($urandom_range(1, 5)) stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
